// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP state encoding, fixed opcodes and IR capture pattern
package jtag_pkg;

  // Standard 1149.1 state encoding, so a logic analyser reading tap_state sees familiar codes
  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  localparam int unsigned OP_EXTEST = 0;
  localparam int unsigned OP_IDCODE = 1;
  localparam int unsigned OP_SAMPLE = 2;
  localparam int unsigned USER_BASE = 2;

  // Low two bits captured into the IR; upper bits are zero-filled to IR width
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - TMS-driven 16-state TAP controller with decoded phase flags
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       in_reset
);

  tap_state_e next_state;

  // State register; TRST overrides TMS
  always_ff @(posedge tck) begin
    if (trst) state <= TAP_TLR;
    else      state <= next_state;
  end

  // Next-state from TMS and per-state phase flags
  always_comb begin
    next_state = state;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    in_reset   = 1'b0;
    case (state)
      TAP_TLR:      begin next_state = tms ? TAP_TLR : TAP_RTI; in_reset = 1'b1; end
      TAP_RTI:      next_state = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   next_state = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   begin next_state = tms ? TAP_EX1_DR : TAP_SH_DR; capture_dr = 1'b1; end
      TAP_SH_DR:    begin next_state = tms ? TAP_EX1_DR : TAP_SH_DR; shift_dr = 1'b1; end
      TAP_EX1_DR:   next_state = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: next_state = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   next_state = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR:   begin next_state = tms ? TAP_SEL_DR : TAP_RTI; update_dr = 1'b1; end
      TAP_SEL_IR:   next_state = tms ? TAP_TLR : TAP_CAP_IR;
      TAP_CAP_IR:   begin next_state = tms ? TAP_EX1_IR : TAP_SH_IR; capture_ir = 1'b1; end
      TAP_SH_IR:    begin next_state = tms ? TAP_EX1_IR : TAP_SH_IR; shift_ir = 1'b1; end
      TAP_EX1_IR:   next_state = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: next_state = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   next_state = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR:   begin next_state = tms ? TAP_SEL_DR : TAP_RTI; update_ir = 1'b1; end
      default:      next_state = TAP_TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctl.sv
// rtl/jtag_tap_ctl.sv - TAP top: IR, opcode decode, IDCODE/BYPASS registers, chain strobes, TDO mux
module jtag_tap_ctl
  import jtag_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          NUM_CH     = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              TDO_EN,
  output logic [3:0]        tap_state,
  output logic [IR_W-1:0]   ir_value,
  output logic [NUM_CH-1:0] dr_sel,
  output logic              dr_capture,
  output logic              dr_shift,
  output logic              dr_update,
  input  logic [NUM_CH-1:0] dr_tdo,
  output logic              ext_test
);

  localparam logic [IR_W-1:0] EXTEST_OP  = IR_W'(OP_EXTEST);
  localparam logic [IR_W-1:0] IDCODE_OP  = IR_W'(OP_IDCODE);
  localparam logic [IR_W-1:0] SAMPLE_OP  = IR_W'(OP_SAMPLE);
  localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, IR_CAPTURE_LSBS};

  tap_state_e      state;
  logic            capture_dr, shift_dr, update_dr;
  logic            capture_ir, shift_ir, update_ir, in_reset;
  logic [IR_W-1:0] ir_shift, ir_reg;
  logic [31:0]     idcode_sr;
  logic            bypass_sr;
  logic            sel_idcode, sel_bypass;

  jtag_tap_fsm u_fsm (
    .tck        (TCK),
    .trst       (TRST),
    .tms        (TMS),
    .state      (state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .in_reset   (in_reset)
  );

  assign tap_state = state;
  // Test_Logic_Reset forces IDCODE immediately, not one edge later
  assign ir_value  = in_reset ? IDCODE_OP : ir_reg;

  // Instruction shift register and the active instruction latch
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_shift <= IR_CAPTURE;
      ir_reg   <= IDCODE_OP;
    end else begin
      if (capture_ir)    ir_shift <= IR_CAPTURE;
      else if (shift_ir) ir_shift <= {TDI, ir_shift[IR_W-1:1]};
      if (in_reset)       ir_reg <= IDCODE_OP;
      else if (update_ir) ir_reg <= ir_shift;
    end
  end

  // Opcode decode: fixed chain-0 opcodes, USER range, IDCODE, everything else BYPASS
  always_comb begin
    dr_sel     = '0;
    sel_idcode = 1'b0;
    sel_bypass = 1'b0;
    if (ir_value == EXTEST_OP || ir_value == SAMPLE_OP) begin
      dr_sel[0] = 1'b1;
    end else if (ir_value == IDCODE_OP) begin
      sel_idcode = 1'b1;
    end else begin
      sel_bypass = 1'b1;
      for (int k = 1; k < NUM_CH; k++) begin
        if (ir_value == IR_W'(USER_BASE + k)) begin
          dr_sel[k]  = 1'b1;
          sel_bypass = 1'b0;
        end
      end
    end
  end

  assign ext_test   = (ir_value == EXTEST_OP);
  assign dr_capture = capture_dr && (dr_sel != '0);
  assign dr_shift   = shift_dr   && (dr_sel != '0);
  assign dr_update  = update_dr  && (dr_sel != '0);

  // Built-in data registers; only the selected one captures or shifts
  always_ff @(posedge TCK) begin
    if (TRST) begin
      idcode_sr <= IDCODE_VAL;
      bypass_sr <= 1'b0;
    end else begin
      if (sel_idcode && capture_dr)    idcode_sr <= IDCODE_VAL;
      else if (sel_idcode && shift_dr) idcode_sr <= {TDI, idcode_sr[31:1]};
      if (sel_bypass && capture_dr)    bypass_sr <= 1'b0;
      else if (sel_bypass && shift_dr) bypass_sr <= TDI;
    end
  end

  // TDO mux from registered state, valid for the whole shift cycle
  always_comb begin
    TDO    = 1'b0;
    TDO_EN = shift_ir || shift_dr;
    if (shift_ir)        TDO = ir_shift[0];
    else if (shift_dr) begin
      if (sel_idcode)      TDO = idcode_sr[0];
      else if (sel_bypass) TDO = bypass_sr;
      else                 TDO = |(dr_tdo & dr_sel);
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctl.sv
// tb/tb_jtag_tap_ctl.sv - directed bench with behavioural TAP model and per-cycle compare
module tb_jtag_tap_ctl;
  import jtag_pkg::*;

  localparam int          IR_W   = 4;
  localparam int          NUM_CH = 2;
  localparam logic [31:0] IDV    = 32'h1000_0001;

  logic              TCK = 1'b0;
  logic              TRST, TMS, TDI;
  logic              TDO, TDO_EN;
  logic [3:0]        tap_state;
  logic [IR_W-1:0]   ir_value;
  logic [NUM_CH-1:0] dr_sel;
  logic              dr_capture, dr_shift, dr_update;
  logic [NUM_CH-1:0] dr_tdo;
  logic              ext_test;

  jtag_tap_ctl #(.IR_W(IR_W), .NUM_CH(NUM_CH), .IDCODE_VAL(IDV)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .tap_state(tap_state), .ir_value(ir_value), .dr_sel(dr_sel),
    .dr_capture(dr_capture), .dr_shift(dr_shift), .dr_update(dr_update),
    .dr_tdo(dr_tdo), .ext_test(ext_test)
  );

  always #5 TCK = ~TCK;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 0;
  int cap_cnt = 0, shift_cnt = 0, upd_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  tap_state_e      m_st;
  logic [IR_W-1:0] m_ir, m_irsh;
  logic [31:0]     m_idc;
  logic            m_byp;

  function automatic tap_state_e m_next(tap_state_e s, logic tms);
    case (s)
      TAP_TLR:      return tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   return tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:    return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR:   return tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   return tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR:   return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   return tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:    return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR:   return tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   return tms ? TAP_UPD_IR : TAP_SH_IR;
      default:      return tms ? TAP_SEL_DR : TAP_RTI;
    endcase
  endfunction

  function automatic logic [IR_W-1:0] m_ir_out();
    return (m_st == TAP_TLR) ? IR_W'(1) : m_ir;
  endfunction

  // -2 = IDCODE, -1 = BYPASS, k >= 0 = external chain k
  function automatic int m_chain();
    int op = int'(m_ir_out());
    if (op == 0 || op == 2) return 0;
    if (op == 1) return -2;
    if (op >= 3 && op <= NUM_CH + 1) return op - 2;
    return -1;
  endfunction

  function automatic logic [NUM_CH-1:0] m_sel();
    logic [NUM_CH-1:0] v = '0;
    if (m_chain() >= 0) v[m_chain()] = 1'b1;
    return v;
  endfunction

  function automatic logic m_tdo();
    if (m_st == TAP_SH_IR) return m_irsh[0];
    if (m_st != TAP_SH_DR) return 1'b0;
    case (m_chain())
      -2:      return m_idc[0];
      -1:      return m_byp;
      default: return dr_tdo[m_chain()];
    endcase
  endfunction

  task automatic m_edge(input logic trst, input logic tms, input logic tdi);
    if (trst) begin
      m_st = TAP_TLR; m_ir = 1; m_irsh = 1; m_idc = IDV; m_byp = 0;
      return;
    end
    case (m_st)
      TAP_CAP_IR: m_irsh = 1;
      TAP_SH_IR:  m_irsh = (m_irsh >> 1) | (IR_W'(tdi) << (IR_W - 1));
      TAP_UPD_IR: m_ir = m_irsh;
      TAP_CAP_DR: begin
        if (m_chain() == -2) m_idc = IDV;
        if (m_chain() == -1) m_byp = 0;
      end
      TAP_SH_DR: begin
        if (m_chain() == -2) m_idc = (m_idc >> 1) | (32'(tdi) << 31);
        if (m_chain() == -1) m_byp = tdi;
      end
      default: ;
    endcase
    if (m_st == TAP_TLR) m_ir = 1;
    m_st = m_next(m_st, tms);
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge TCK) begin
    if (run_cmp) begin
      chk("tap_state", 64'(tap_state), 64'(m_st));
      chk("ir_value", 64'(ir_value), 64'(m_ir_out()));
      chk("dr_sel", 64'(dr_sel), 64'(m_sel()));
      chk("ext_test", 64'(ext_test), 64'(m_ir_out() == 0));
      chk("tdo_en", 64'(TDO_EN), 64'(m_st == TAP_SH_IR || m_st == TAP_SH_DR));
      chk("tdo", 64'(TDO), 64'(m_tdo()));
      chk("dr_capture", 64'(dr_capture), 64'(m_st == TAP_CAP_DR && m_sel() != 0));
      chk("dr_shift", 64'(dr_shift), 64'(m_st == TAP_SH_DR && m_sel() != 0));
      chk("dr_update", 64'(dr_update), 64'(m_st == TAP_UPD_DR && m_sel() != 0));
      if (dr_capture) cap_cnt++;
      if (dr_shift)   shift_cnt++;
      if (dr_update)  upd_cnt++;
    end
  end

  task automatic tck(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    m_edge(TRST, tms, tdi);
    #1;
    dr_tdo = NUM_CH'($urandom);
  endtask

  // From Run_Test_Idle: load an IR opcode, return the bits seen on TDO (first at bit 0)
  task automatic load_ir(input logic [IR_W-1:0] op, output logic [IR_W-1:0] seen);
    tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
    for (int i = 0; i < IR_W; i++) begin
      seen[i] = TDO;
      tck(i == IR_W - 1, op[i]);
    end
    tck(1, 0); tck(0, 0);
  endtask

  // From Run_Test_Idle: shift n DR bits, ending back in Run_Test_Idle through Update_DR
  task automatic shift_dr(input int n, input logic [63:0] tdi, output logic [63:0] seen);
    seen = '0;
    tck(1, 0); tck(0, 0); tck(0, 0);
    for (int i = 0; i < n; i++) begin
      seen[i] = TDO;
      tck(i == n - 1, tdi[i]);
    end
    tck(1, 0); tck(0, 0);
  endtask

  logic [IR_W-1:0] irs;
  logic [63:0]     dro;

  initial begin
    TRST = 1; TMS = 0; TDI = 0; dr_tdo = '0;
    tck(0, 0);
    run_cmp = 1;
    chk("rst_state", 64'(tap_state), 64'h F);
    chk("rst_ir", 64'(ir_value), 64'd1);
    chk("rst_tdo", 64'({TDO, TDO_EN}), 64'd0);
    chk("rst_sel_strobes", 64'({dr_sel, dr_capture, dr_shift, dr_update, ext_test}), 64'd0);
    TRST = 0;

    tck(0, 0);
    chk("rti_state", 64'(tap_state), 64'h C);
    chk("rti_ir", 64'(ir_value), 64'd1);

    shift_dr(32, 64'h0, dro);
    chk("idcode_out", dro[31:0], 64'h1000_0001);

    tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0); tck(1, 0); tck(0, 0);
    chk("pause_ir", 64'(tap_state), 64'h B);
    for (int i = 0; i < 5; i++) tck(1, 0);
    chk("tms5_state", 64'(tap_state), 64'h F);
    chk("tms5_ir", 64'(ir_value), 64'd1);
    tck(0, 0);

    load_ir(4'hF, irs);
    shift_dr(4, 64'b1101, dro);
    chk("bypass_out", dro[3:0], 64'b1010);

    load_ir(4'h0, irs);
    chk("extest_flag", 64'(ext_test), 64'd1);
    chk("extest_sel", 64'(dr_sel), 64'b01);
    cap_cnt = 0; shift_cnt = 0; upd_cnt = 0;
    shift_dr(51, {$urandom, $urandom}, dro);
    chk("extest_caps", 64'(cap_cnt), 64'd1);
    chk("extest_shifts", 64'(shift_cnt), 64'd51);
    chk("extest_updates", 64'(upd_cnt), 64'd1);

    load_ir(4'h3, irs);
    chk("ir_capture_out", 64'(irs), 64'b0001);
    chk("user1_sel", 64'(dr_sel), 64'b10);
    chk("user1_ext_test", 64'(ext_test), 64'd0);
    shift_dr(8, 64'hA5, dro);

    load_ir(4'h9, irs);
    chk("op9_sel", 64'(dr_sel), 64'd0);
    shift_dr(4, 64'b0110, dro);
    chk("op9_bypass_out", dro[3:0], 64'b1100);

    load_ir(4'h3, irs);
    upd_cnt = 0;
    tck(1, 0); tck(0, 0); tck(0, 0);
    tck(0, 1); tck(0, 0); tck(0, 1);
    TRST = 1;
    tck(1, 0);
    TRST = 0;
    chk("trst_state", 64'(tap_state), 64'h F);
    chk("trst_ir", 64'(ir_value), 64'd1);
    tck(1, 0); tck(0, 0);
    chk("trst_no_update", 64'(upd_cnt), 64'd0);
    shift_dr(32, 64'h0, dro);
    chk("idcode_after_trst", dro[31:0], 64'h1000_0001);

    run_cmp = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
